// File: rtl/datapath_sequencer.sv
// Four-state instruction sequencer: accepts one 16-bit instruction at a time,
// decodes it and steps through DECODE, EXEC and WB, driving the ALU and
// register-file control signals from the state and the latched instruction.
module datapath_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [15:0] re,
    output logic [3:0]  rs,
    output logic [3:0]  rd,
    output logic [4:0]  opcode,
    output logic        ri,
    output logic [15:0] imm,
    output logic        fe,
    output logic        busy,
    output logic        illegal,
    output logic [7:0]  icount
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDecode = 2'd1,
        StExec   = 2'd2,
        StWb     = 2'd3
    } state_e;

    state_e      r_state;
    logic [15:0] r_ir;
    logic [7:0]  r_icount;

    logic [3:0]  w_class;
    logic [3:0]  w_ext;
    logic        w_legal;
    logic        w_compare;
    logic [4:0]  w_opcode;
    logic [15:0] w_imm;
    logic [15:0] w_re_onehot;

    assign w_class = r_ir[15:12];
    assign w_ext   = r_ir[7:4];

    // Legality of the latched instruction class / ext combination.
    always_comb begin
        w_legal = 1'b1;
        case (w_class)
            4'h4, 4'hC, 4'hE: w_legal = 1'b0;
            4'h8: begin
                case (w_ext)
                    4'h0, 4'h2, 4'h4, 4'h6: w_legal = 1'b1;
                    default:                w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b1;
        endcase
    end

    // ALU opcode: register class uses ext, class 8 maps to shift/rotate ops.
    always_comb begin
        w_opcode = {1'b0, w_class};
        if (w_class == 4'h0) begin
            w_opcode = {1'b0, w_ext};
        end else if (w_class == 4'h8) begin
            case (w_ext)
                4'h0, 4'h4: w_opcode = 5'b11100;
                4'h6:       w_opcode = 5'b10011;
                4'h2:       w_opcode = 5'b10111;
                default:    w_opcode = {1'b0, w_class};
            endcase
        end
    end

    // Shift amounts are a zero-extended nibble; everything else a signed byte.
    assign w_imm = (w_class == 4'h8) ? {12'h000, r_ir[3:0]} : {{8{r_ir[7]}}, r_ir[7:0]};

    // Compares update flags only and never write the register file.
    assign w_compare   = (w_class == 4'hB) || ((w_class == 4'h0) && (w_ext == 4'hB));
    assign w_re_onehot = 16'd1 << r_ir[11:8];

    // Sequencer state, instruction register and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_ir     <= 16'h0000;
            r_icount <= 8'h00;
        end else begin
            case (r_state)
                StIdle: begin
                    if (instr_valid) begin
                        r_ir    <= instr;
                        r_state <= StDecode;
                    end
                end
                StDecode: r_state <= w_legal ? StExec : StIdle;
                StExec:   r_state <= StWb;
                StWb: begin
                    r_state  <= StIdle;
                    r_icount <= r_icount + 8'd1;
                end
                default:  r_state <= StIdle;
            endcase
        end
    end

    // Output decode from state and the latched instruction.
    always_comb begin
        instr_ready = 1'b0;
        re          = 16'h0000;
        rs          = 4'h0;
        rd          = 4'h0;
        opcode      = 5'h00;
        ri          = 1'b0;
        imm         = 16'h0000;
        fe          = 1'b0;
        illegal     = 1'b0;
        unique case (r_state)
            // Reset forces IDLE already; ready is additionally held low while rst is high.
            StIdle:   instr_ready = ~rst;
            StDecode: illegal = ~w_legal;
            StExec: begin
                rs     = r_ir[3:0];
                rd     = r_ir[11:8];
                opcode = w_opcode;
                ri     = (w_class != 4'h0);
                imm    = w_imm;
                fe     = 1'b1;
            end
            StWb: begin
                rs     = r_ir[3:0];
                rd     = r_ir[11:8];
                opcode = w_opcode;
                ri     = (w_class != 4'h0);
                imm    = w_imm;
                re     = w_compare ? 16'h0000 : w_re_onehot;
            end
        endcase
    end

    assign busy   = (r_state != StIdle);
    assign icount = r_icount;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: a driver pushes expected responses
// on acceptance, a monitor pops and compares whenever the DUT shows a decode
// (illegal pulse) or an execute (fe) cycle.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_ready;
    logic [15:0] re;
    logic [3:0]  rs;
    logic [3:0]  rd;
    logic [4:0]  opcode;
    logic        ri;
    logic [15:0] imm;
    logic        fe;
    logic        busy;
    logic        illegal;
    logic [7:0]  icount;

    datapath_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .re          (re),
        .rs          (rs),
        .rd          (rd),
        .opcode      (opcode),
        .ri          (ri),
        .imm         (imm),
        .fe          (fe),
        .busy        (busy),
        .illegal     (illegal),
        .icount      (icount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] instr;
        int          acc;
        bit          legal;
        logic [3:0]  rs;
        logic [3:0]  rd;
        logic [4:0]  opc;
        bit          ri;
        logic [15:0] imm;
        logic [15:0] re;
    } exp_t;

    exp_t       stim_q[$];
    exp_t       sb_q[$];
    exp_t       cur;
    bit         wb_pend = 1'b0;
    bit         rdy_pend = 1'b0;
    logic [7:0] m_icount = 8'h00;
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
    endtask

    // Reference model: the instruction set rules written as plain arithmetic.
    function automatic exp_t model(input logic [15:0] w);
        exp_t e;
        int   cls;
        int   ext;
        int   simm;
        cls = int'(w[15:12]);
        ext = int'(w[7:4]);
        e.instr = w;
        e.acc   = 0;
        e.legal = !(cls == 4 || cls == 12 || cls == 14) &&
                  !(cls == 8 && !(ext == 0 || ext == 2 || ext == 4 || ext == 6));
        e.rs = w[3:0];
        e.rd = w[11:8];
        e.ri = (cls != 0);
        if (cls == 0) e.opc = 5'(ext);
        else if (cls == 8 && (ext == 0 || ext == 4)) e.opc = 5'd28;
        else if (cls == 8 && ext == 6) e.opc = 5'd19;
        else if (cls == 8 && ext == 2) e.opc = 5'd23;
        else e.opc = 5'(cls);
        simm = int'(w[7:0]);
        if (simm >= 128) simm = simm - 256;
        e.imm = (cls == 8) ? 16'(int'(w[3:0])) : 16'(simm);
        e.re  = (cls == 11 || (cls == 0 && ext == 11)) ? 16'h0000 : 16'(1 << int'(w[11:8]));
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] w, input bit legal, input logic [3:0] s,
                                input logic [3:0] d, input logic [4:0] o, input bit i,
                                input logic [15:0] im, input logic [15:0] r);
        exp_t e;
        e.instr = w; e.acc = 0; e.legal = legal; e.rs = s; e.rd = d;
        e.opc = o; e.ri = i; e.imm = im; e.re = r;
        return e;
    endfunction

    // Monitor: DECODE cycle of an accepted instruction is the negedge where cyc == acc.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            chk("rst_outputs", 64'({re, rs, rd, opcode, ri, imm, fe, illegal, busy, instr_ready}),
                64'd0);
            chk("rst_icount", 64'(icount), 64'd0);
            sb_q.delete();
            wb_pend  = 1'b0;
            rdy_pend = 1'b0;
            m_icount = 8'h00;
        end else begin
            if (rdy_pend) begin
                chk("ready_after", 64'(instr_ready), 64'd1);
                chk("busy_after", 64'(busy), 64'd0);
                chk("icount", 64'(icount), 64'(m_icount));
                rdy_pend = 1'b0;
            end
            if (wb_pend) begin
                chk("wb_re", 64'(re), 64'(cur.re));
                chk("wb_fe", 64'(fe), 64'd0);
                chk("wb_hold", 64'({rs, rd, opcode, ri, imm}),
                    64'({cur.rs, cur.rd, cur.opc, cur.ri, cur.imm}));
                chk("wb_ready", 64'(instr_ready), 64'd0);
                m_icount = m_icount + 8'd1;
                wb_pend  = 1'b0;
                rdy_pend = 1'b1;
            end else begin
                chk("stray_re", 64'(re), 64'd0);
            end
            if (illegal) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_illegal", 64'(illegal), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("illegal_flag", 64'(illegal), 64'(!e.legal));
                    chk("illegal_cycle", 64'(cyc), 64'(e.acc));
                    chk("decode_zero", 64'({re, rs, rd, opcode, ri, imm, fe}), 64'd0);
                    chk("decode_ready", 64'(instr_ready), 64'd0);
                    rdy_pend = 1'b1;
                end
            end
            if (fe) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_exec", 64'(fe), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("exec_flag", 64'(fe), 64'(e.legal));
                    chk("exec_cycle", 64'(cyc), 64'(e.acc + 1));
                    chk("exec_rs", 64'(rs), 64'(e.rs));
                    chk("exec_rd", 64'(rd), 64'(e.rd));
                    chk("exec_opcode", 64'(opcode), 64'(e.opc));
                    chk("exec_ri", 64'(ri), 64'(e.ri));
                    chk("exec_imm", 64'(imm), 64'(e.imm));
                    chk("exec_ready_busy_ill", 64'({instr_ready, busy, illegal}), 64'b010);
                    cur     = e;
                    wb_pend = e.legal;
                end
            end
            if (sb_q.size() != 0 && cyc > sb_q[0].acc + 1) begin
                void'(sb_q.pop_front());
                fail_now("decode_or_exec_timeout");
            end
        end
    end

    // Driver: presents instructions only when ready, garbage instr while busy.
    task automatic drive_all(input bit b2b, input int max_gap);
        int   prev_acc;
        bit   first;
        bit   took;
        int   gap;
        exp_t e;
        prev_acc = 0;
        first    = 1'b1;
        gap      = 0;
        while (stim_q.size() > 0) begin
            @(negedge clk);
            took = 1'b0;
            if (instr_ready && gap > 0) begin
                gap--;
                instr_valid = 1'b0;
                instr       = 16'($urandom);
            end else if (instr_ready) begin
                took        = 1'b1;
                instr_valid = 1'b1;
                instr       = stim_q[0].instr;
            end else begin
                instr_valid = b2b ? 1'b1 : 1'($urandom);
                instr       = 16'($urandom);
            end
            @(posedge clk);
            #1;
            if (took) begin
                e     = stim_q.pop_front();
                e.acc = cyc;
                sb_q.push_back(e);
                if (b2b && !first) chk("accept_rate", 64'(cyc - prev_acc), 64'd4);
                prev_acc = cyc;
                first    = 1'b0;
                gap      = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            end
        end
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || wb_pend || rdy_pend) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_done", 64'(n < 50), 64'd1);
    endtask

    initial begin
        logic [15:0] w;
        #22;
        rst = 1'b0;

        // Directed: ADD R3,R5; immediate; shift; illegal.
        stim_q.push_back(mk(16'h0355, 1'b1, 4'h5, 4'h3, 5'b00101, 1'b0, 16'h0055, 16'h0008));
        stim_q.push_back(mk(16'h52F0, 1'b1, 4'h0, 4'h2, 5'b00101, 1'b1, 16'hFFF0, 16'h0004));
        stim_q.push_back(mk(16'h8163, 1'b1, 4'h3, 4'h1, 5'b10011, 1'b1, 16'h0003, 16'h0002));
        stim_q.push_back(mk(16'h4000, 1'b0, 4'h0, 4'h0, 5'b00000, 1'b0, 16'h0000, 16'h0000));
        drive_all(1'b0, 2);
        drain();

        // Random mix of legal and illegal words with idle gaps.
        for (int i = 0; i < 40; i++) stim_q.push_back(model(16'($urandom)));
        drive_all(1'b0, 3);
        drain();

        // Asynchronous reset in the middle of EXEC.
        stim_q.push_back(model(16'h0355));
        drive_all(1'b0, 0);
        @(posedge clk);
        #3;
        chk("pre_reset_exec_fe", 64'(fe), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs",
            64'({re, rs, rd, opcode, ri, imm, fe, illegal, busy, instr_ready}), 64'd0);
        chk("async_rst_icount", 64'(icount), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_ready", 64'(instr_ready), 64'd1);
        chk("post_rst_icount", 64'(icount), 64'd0);

        // 260 back-to-back legal instructions with valid held high.
        for (int i = 0; i < 260; i++) begin
            if (i == 100) begin
                stim_q.push_back(mk(16'h0EB1, 1'b1, 4'h1, 4'hE, 5'b01011, 1'b0, 16'hFFB1, 16'h0));
            end else begin
                w = 16'($urandom);
                while (!model(w).legal) w = 16'($urandom);
                stim_q.push_back(model(w));
            end
        end
        drive_all(1'b1, 0);
        drain();
        chk("icount_wrap", 64'(icount), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  16  instruction word: [15:12] class, [11:8] rd, [7:4] ext, [3:0] rs
- re  out  16  register-file write enables, one-hot or zero
- rs  out  4  source register mux select
- rd  out  4  destination register mux select
- opcode  out  5  ALU opcode
- ri  out  1  1 = ALU B operand from imm, 0 = from rs
- imm  out  16  immediate operand
- fe  out  1  ALU flag-register enable
- busy  out  1  sequencer is not in IDLE
- illegal  out  1  unsupported instruction rejected
- icount  out  8  count of retired instructions

Function
REQ-003 The FSM SHALL have four states, IDLE, DECODE, EXEC and WB, encoded in 2 bits, and all outputs SHALL be decoded from the state and the latched instruction register ir only.
REQ-004 instr_ready SHALL be 1 in IDLE and 0 in every other state; busy SHALL equal the inverse of instr_ready.
REQ-005 When instr_valid=1 and instr_ready=1 at a rising edge, the block SHALL latch instr into ir and go to DECODE; if instr_valid=0, it SHALL stay in IDLE.
REQ-006 The legal instruction classes SHALL be:
- 0000 with any ext
- 0001, 0010, 0011, 0101, 0110, 0111, 1001, 1010, 1011, 1101, 1111
- 1000 only with ext 0000, 0010, 0100 or 0110
All other encodings SHALL be illegal.
REQ-007 In DECODE, every datapath output SHALL be 0, and illegal SHALL be 1 for exactly this cycle if ir is illegal.
REQ-008 On leaving DECODE, an illegal ir SHALL send the FSM to IDLE with no EXEC, no WB and no icount change; a legal ir SHALL send it to EXEC.
REQ-009 In EXEC the block SHALL drive:
- rd=ir[11:8] and rs=ir[3:0]
- fe=1 and re=0
- ri = 0 when class is 0000, otherwise 1
REQ-010 opcode SHALL be decoded as follows:
- class 0000 -> {0, ext}
- class 1000 with ext 0100 or 0000 -> 11100
- class 1000 with ext 0110 -> 10011
- class 1000 with ext 0010 -> 10111
- any other class -> {0, class}
REQ-011 imm SHALL be zero-extended ir[3:0] for class 1000, and otherwise sign-extended ir[7:0] (e.g. 0x80 -> 0xFF80).
REQ-012 In WB, rs, rd, opcode, ri and imm SHALL hold their EXEC values, fe SHALL be 0, and re SHALL be the one-hot decode of rd (bit rd = 1).
REQ-013 In WB, re SHALL be 0 for compare instructions: class 1011, or class 0000 with ext 1011.
REQ-014 WB SHALL always go to IDLE, and icount SHALL increment by 1 on that edge, wrapping from 255 to 0.
REQ-015 In IDLE, every datapath output and illegal SHALL be 0.
REQ-016 Latency: an instruction accepted at edge N SHALL give DECODE in cycle N+1, EXEC in N+2, WB in N+3, and instr_ready=1 again in N+4, for a throughput of one instruction per 4 cycles.
REQ-017 instr SHALL be ignored outside IDLE, and a change of instr after acceptance SHALL NOT affect the outputs.

Reset
REQ-018 While rst=1, regardless of clk, the block SHALL:
- hold state=IDLE, ir=0 and icount=0
- drive re, rs, rd, opcode, ri, imm, fe, illegal and busy to 0
- drive instr_ready to 0
REQ-019 Reset asserted in DECODE, EXEC or WB SHALL abort the instruction with no write enable, no icount increment and no illegal pulse; after rst falls, the FSM SHALL be in IDLE with instr_ready=1.

Verification
REQ-020 A bench SHALL cover an ADD R3,R5 (instr 0x0355) accepted at edge N. Required response:
- cycle N+2: rs=5, rd=3, opcode=00101, ri=0, fe=1, re=0
- cycle N+3: re=0x0008, fe=0
- icount 0 -> 1
REQ-021 A bench SHALL cover an immediate instruction with instr 0x52F0. Required response:
- EXEC: ri=1, imm=0xFFF0, opcode=00101, rd=2
- WB: re=0x0004
REQ-022 A bench SHALL cover a shift with instr 0x8163. Required response:
- EXEC: opcode=10011, imm=0x0003, ri=1
- WB: re=0x0002
REQ-023 A bench SHALL cover an illegal instr 0x4000. Required response:
- illegal=1 for one cycle in N+1
- instr_ready=1 at N+2
- re is never nonzero and icount is unchanged
REQ-024 A bench SHALL hold instr_valid=1 for 260 back-to-back legal instructions. Required response:
- one acceptance every 4 cycles
- icount wraps to 4
- a compare (instr 0x0EB1) gives re=0 in WB
REQ-025 A bench SHALL assert rst asynchronously mid-EXEC. Required response:
- all outputs go to 0 at once, with no re pulse
- after release, instr_ready=1 and icount=0
